// File: rtl/pc_pkg.sv
// Shared types and helpers for the program-counter / fetch-address generator.
//   pcsrc_t       : next-PC source select (sequential, branch/JAL, JALR, trap)
//   fetch_state_t : fetch FSM states (BOOT, RUN, HOLD)
//   INSTR_BYTES   : sequential PC increment
//   misaligned_f  : instruction-alignment test on the low address bits
package pc_pkg;

  typedef enum logic [1:0] {
    PC_SEQ    = 2'b00,
    PC_BRANCH = 2'b01,
    PC_JALR   = 2'b10,
    PC_TRAP   = 2'b11
  } pcsrc_t;

  typedef enum logic [1:0] {
    BOOT = 2'b00,
    RUN  = 2'b01,
    HOLD = 2'b10
  } fetch_state_t;

  localparam int INSTR_BYTES = 4;

  // With 16-bit alignment (compressed instructions) only bit 0 must be clear;
  // with 32-bit alignment both low bits must be clear.
  function automatic logic misaligned_f(input logic [1:0] low_bits, input int ialign);
    logic bad_s;
    if (ialign == 16) begin
      bad_s = low_bits[0];
    end else begin
      bad_s = low_bits[1] | low_bits[0];
    end
    return bad_s;
  endfunction

endpackage

// File: rtl/pc_target_check.sv
// Redirect target conditioning: JALR bit-0 masking followed by the
// instruction-alignment check on the masked value.
//   jalr       in  : raw value is a JALR target, clear bit 0 first
//   raw        in  : unconditioned redirect target
//   target     out : conditioned target
//   misaligned out : conditioned target violates IALIGN
module pc_target_check
  import pc_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int IALIGN = 32
) (
  input  logic            jalr,
  input  logic [XLEN-1:0] raw,
  output logic [XLEN-1:0] target,
  output logic            misaligned
);

  // Mask then check, so a JALR to an odd address lands on the even byte below it.
  always_comb begin
    target = raw;
    if (jalr) begin
      target[0] = 1'b0;
    end else begin
      target[0] = raw[0];
    end
    misaligned = misaligned_f(target[1:0], IALIGN);
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// Program-counter / fetch-address generator with fetch handshake, stall hold,
// buffered redirect, trap vectoring and target alignment checking.
//   CLK, Reset_n   : clock (rising edge), asynchronous active-low reset
//   Stall          : pipeline hazard stall, blocks PC advance
//   PCSrc          : 00 seq, 01 branch/JAL (PCTarget), 10 JALR (ALUResult), 11 trap
//   PCTarget       : branch/JAL target
//   ALUResult      : JALR target (bit 0 masked)
//   FetchReady     : instruction memory accepts the address this cycle
//   FetchValid     : PC is a valid fetch request
//   PC, PCPlus4    : current fetch address and its sequential successor
//   MisalignFault  : one-cycle pulse after a misaligned target was committed
//   FaultPC        : offending target of the most recent fault
module pc_fetch_unit
  import pc_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(32'h0000_0000),
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h0000_0100),
  parameter int              IALIGN       = 32
) (
  input  logic            CLK,
  input  logic            Reset_n,
  input  logic            Stall,
  input  logic [1:0]      PCSrc,
  input  logic [XLEN-1:0] PCTarget,
  input  logic [XLEN-1:0] ALUResult,
  input  logic            FetchReady,
  output logic            FetchValid,
  output logic [XLEN-1:0] PC,
  output logic [XLEN-1:0] PCPlus4,
  output logic            MisalignFault,
  output logic [XLEN-1:0] FaultPC
);

  // Elaboration-time parameter sanity.
  if ((IALIGN != 32) && (IALIGN != 16)) begin : g_bad_ialign
    $error("pc_fetch_unit: IALIGN must be 16 or 32");
  end
  if (misaligned_f(TRAP_VECTOR[1:0], IALIGN)) begin : g_bad_trap_vector
    $error("pc_fetch_unit: TRAP_VECTOR is not IALIGN-aligned");
  end

  fetch_state_t    state_r, state_s;
  logic [XLEN-1:0] pc_r, pc_s;
  logic [XLEN-1:0] pending_r, pending_s;
  logic [XLEN-1:0] fault_pc_r, fault_pc_s;
  logic            fetch_valid_r, fetch_valid_s;
  logic            fault_r, fault_s;

  pcsrc_t          pcsrc_s;
  logic            advance_s;
  logic            live_redirect_s;
  logic            take_redirect_s;
  logic            take_seq_s;
  logic [XLEN-1:0] pc_plus4_s;
  logic [XLEN-1:0] commit_raw_s;
  logic            commit_jalr_s;
  logic [XLEN-1:0] commit_target_s;
  logic            commit_misaligned_s;

  assign pcsrc_s         = pcsrc_t'(PCSrc);
  assign advance_s       = fetch_valid_r & FetchReady & ~Stall;
  assign live_redirect_s = (pcsrc_s != PC_SEQ);
  assign pc_plus4_s      = pc_r + XLEN'(INSTR_BYTES);

  // Redirect source: a live redirect always beats the buffered one, so the
  // same conditioned value serves both as capture input and commit target.
  always_comb begin
    commit_raw_s  = pending_r;
    commit_jalr_s = 1'b0;
    case (pcsrc_s)
      PC_BRANCH: commit_raw_s = PCTarget;
      PC_JALR: begin
        commit_raw_s  = ALUResult;
        commit_jalr_s = 1'b1;
      end
      PC_TRAP:   commit_raw_s = TRAP_VECTOR;
      default:   commit_raw_s = pending_r;
    endcase
  end

  pc_target_check #(
    .XLEN   (XLEN),
    .IALIGN (IALIGN)
  ) u_target_check (
    .jalr       (commit_jalr_s),
    .raw        (commit_raw_s),
    .target     (commit_target_s),
    .misaligned (commit_misaligned_s)
  );

  // Fetch FSM next state, redirect buffering and PC-update selection.
  always_comb begin
    state_s         = state_r;
    fetch_valid_s   = fetch_valid_r;
    pending_s       = pending_r;
    take_redirect_s = 1'b0;
    take_seq_s      = 1'b0;
    case (state_r)
      BOOT: begin
        state_s       = RUN;
        fetch_valid_s = 1'b1;
      end
      RUN: begin
        if (advance_s) begin
          if (live_redirect_s) begin
            take_redirect_s = 1'b1;
          end else begin
            take_seq_s = 1'b1;
          end
        end else if (live_redirect_s) begin
          pending_s = commit_target_s;
          state_s   = HOLD;
        end else begin
          state_s = RUN;
        end
      end
      HOLD: begin
        if (advance_s) begin
          take_redirect_s = 1'b1;
          pending_s       = {XLEN{1'b0}};
          state_s         = RUN;
        end else if (live_redirect_s) begin
          pending_s = commit_target_s;
        end else begin
          pending_s = pending_r;
        end
      end
      default: begin
        state_s       = BOOT;
        fetch_valid_s = 1'b0;
        pending_s     = {XLEN{1'b0}};
      end
    endcase
  end

  // PC and fault datapath; a misaligned commit vectors to the trap handler.
  always_comb begin
    pc_s       = pc_r;
    fault_s    = 1'b0;
    fault_pc_s = fault_pc_r;
    if (take_redirect_s) begin
      if (commit_misaligned_s) begin
        pc_s       = TRAP_VECTOR;
        fault_s    = 1'b1;
        fault_pc_s = commit_target_s;
      end else begin
        pc_s = commit_target_s;
      end
    end else if (take_seq_s) begin
      pc_s = pc_plus4_s;
    end else begin
      pc_s = pc_r;
    end
  end

  // State, PC, pending and fault registers.
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      state_r       <= BOOT;
      fetch_valid_r <= 1'b0;
      pc_r          <= RESET_VECTOR;
      pending_r     <= {XLEN{1'b0}};
      fault_r       <= 1'b0;
      fault_pc_r    <= {XLEN{1'b0}};
    end else begin
      state_r       <= state_s;
      fetch_valid_r <= fetch_valid_s;
      pc_r          <= pc_s;
      pending_r     <= pending_s;
      fault_r       <= fault_s;
      fault_pc_r    <= fault_pc_s;
    end
  end

  assign FetchValid    = fetch_valid_r;
  assign PC            = pc_r;
  assign PCPlus4       = pc_plus4_s;
  assign MisalignFault = fault_r;
  assign FaultPC       = fault_pc_r;

endmodule
